aes_128_inv: RTL

- Iterative AES-128 inverse cipher (FIPS-197 §5.3). Decrypts one 128-bit ciphertext block in 10 round cycles.
- Consumes the same 11-entry round-key bus that aes_128_key produces for the encrypt pipeline, so a single key expander serves both directions.
- Sits beside aes_128 on the receive path and closes the loop: anything aes_128 encrypts, this block decrypts.

---
 rtl/aes_128_inv.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_128_inv.sv
// Iterative AES-128 inverse cipher: one ciphertext block per 10 round cycles.
// It uses the same 11-entry round-key bus as the encrypt side, so one key
// expander can serve both directions.
module aes_128_inv #(
   parameter bit KEY_LATCH = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [10:0][127:0]    aes_key_i,
   input  logic                  aes_data_vld_i,
   output logic                  aes_data_rdy_o,
   input  logic [127:0]          aes_data_i,
   output logic                  aes_data_vld_o,
   input  logic                  aes_data_rdy_i,
   output logic [127:0]          aes_data_o
);

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned NUM_RK = 11;
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(10);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   // Inverse S-box, entry n at index n.
   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (09/0b/0d/0e only need bits 0..3).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8, p;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      p  = 8'h00;
      if (k[0]) p = p ^ a;
      if (k[1]) p = p ^ x2;
      if (k[2]) p = p ^ x4;
      if (k[3]) p = p ^ x8;
      return p;
   endfunction

   // InvMixColumns on one column, row 0 in the top byte.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      b1 = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      b2 = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      b3 = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
      return {b0, b1, b2, b3};
   endfunction

   // InvMixColumns across the four columns of the state.
   function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   // InvShiftRows: row r rotates right by r; byte n sits at row n%4, column n/4.
   function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      int dst;
      int src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            dst = r + 4 * c;
            src = r + 4 * ((c - r + 4) % 4);
            o[127-8*dst -: 8] = s[127-8*src -: 8];
         end
      end
      return o;
   endfunction

   // InvSubBytes: sixteen parallel inverse S-box lookups.
   function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      end
      return o;
   endfunction

   fsm_t                    fsm_q, fsm_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [BLK_W-1:0]        state_q;
   logic                    rdy_q, vld_q;
   logic                    rdy_d, vld_d;
   logic                    accept;
   logic [10:0][127:0]      rk_bus;
   logic [CNT_W-1:0]        rk_idx;
   logic [BLK_W-1:0]        rk;
   logic [BLK_W-1:0]        sub_out;
   logic [BLK_W-1:0]        ark_out;
   logic [BLK_W-1:0]        round_out;

   assign accept = (fsm_q == IDLE) && aes_data_vld_i;

   // Round-key source: a private copy taken at accept, or the live bus.
   if (KEY_LATCH) begin : g_key_latch
      logic [10:0][127:0] key_q;

      // Snapshot all round keys when a block is accepted.
      always_ff @(posedge clk) begin
         if (rst) begin
            key_q <= '0;
         end else if (accept) begin
            key_q <= aes_key_i;
         end
      end

      assign rk_bus = key_q;
   end else begin : g_key_live
      assign rk_bus = aes_key_i;
   end

   // Round cnt consumes rk[10-cnt].
   always_comb begin
      rk_idx = LAST_ROUND - cnt_q;
      rk     = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (rk_idx == CNT_W'(i)) rk = rk_bus[i];
      end
   end

   // Shared round datapath; the last round skips InvMixColumns.
   always_comb begin
      sub_out   = inv_sub_bytes(inv_shift_rows(state_q));
      ark_out   = sub_out ^ rk;
      round_out = (cnt_q == LAST_ROUND) ? ark_out : inv_mix_columns(ark_out);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (aes_data_vld_i) fsm_d = RUN;
         RUN:     if (cnt_q == LAST_ROUND) fsm_d = DONE;
         DONE:    if (aes_data_rdy_i) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // FSM output decode, taken from the next state so the flops track fsm_q.
   always_comb begin
      rdy_d = 1'b0;
      vld_d = 1'b0;
      case (fsm_d)
         IDLE:    rdy_d = 1'b1;
         DONE:    vld_d = 1'b1;
         default: ;
      endcase
   end

   // Handshake output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q <= 1'b1;
         vld_q <= 1'b0;
      end else begin
         rdy_q <= rdy_d;
         vld_q <= vld_d;
      end
   end

   // State and round counter: initial AddRoundKey on accept, one round per edge in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (accept) begin
                  state_q <= aes_data_i ^ aes_key_i[10];
                  cnt_q   <= CNT_W'(1);
               end
            end
            RUN: begin
               state_q <= round_out;
               cnt_q   <= (cnt_q == LAST_ROUND) ? '0 : cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign aes_data_rdy_o = rdy_q;
   assign aes_data_vld_o = vld_q;
   assign aes_data_o     = state_q;

endmodule
